// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizes for the two-producer FIFO access controller.
package fifo_arb_pkg;
  localparam int DEPTH_DEF = 8;
  localparam int WIDTH_DEF = 15;

  typedef enum logic [2:0] {
    OP_IDLE  = 3'd0,
    OP_WR    = 3'd1,
    OP_RD    = 3'd2,
    OP_WR_RD = 3'd3,
    OP_FLUSH = 3'd4
  } op_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin write arbiter; last_q remembers the most recent grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_masked,
  input  logic       enable,
  output logic [1:0] gnt_next
);
  logic last_q;

  // On a tie the index that was not granted last wins; a lone requester always wins.
  always_comb begin
    gnt_next = 2'b00;
    if (enable) begin
      if (req_masked == 2'b11) gnt_next = last_q ? 2'b01 : 2'b10;
      else                     gnt_next = req_masked;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            last_q <= 1'b1;
    else if (gnt_next[0]) last_q <= 1'b0;
    else if (gnt_next[1]) last_q <= 1'b1;
  end
endmodule

// File: rtl/fifo_arbiter.sv
// FIFO access controller: round-robin write port, pulsed reads, pointers and flags.
// Optional FIFO_ARB_ERR_EN adds sticky ovf_seen/udf_seen drop indicators.
module fifo_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic             rd_req,
  input  logic             flush,
  output logic [1:0]       gnt,
  output logic             rd_ack,
  output logic             wen,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             ren,
  output logic [AW-1:0]    rd_addr,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
`ifdef FIFO_ARB_ERR_EN
  output logic             ovf_seen,
  output logic             udf_seen,
`endif
  output op_t              op_state
);
  // Handshake: a producer holds req[i] and din stable until gnt[i] pulses for one
  // cycle, then drops req; req[i] sampled while gnt[i] is high is ignored.
  op_t              op_q, op_d;
  logic [AW:0]      wptr_q, rptr_q;
  logic [1:0]       gnt_q, gnt_next, req_masked;
  logic [AW-1:0]    wr_addr_q, rd_addr_q;
  logic [WIDTH-1:0] wr_data_q;
  logic             wr_ok, rd_ok;

  assign count      = wptr_q - rptr_q;
  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign req_masked = req & ~gnt_q;

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .reset      (reset),
    .req_masked (req_masked),
    .enable     (!flush && !full),
    .gnt_next   (gnt_next)
  );

  assign wr_ok = |gnt_next;
  assign rd_ok = rd_req && !empty && !flush;

  always_comb begin
    op_d = OP_IDLE;
    if (flush)               op_d = OP_FLUSH;
    else if (wr_ok && rd_ok) op_d = OP_WR_RD;
    else if (wr_ok)          op_d = OP_WR;
    else if (rd_ok)          op_d = OP_RD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= OP_IDLE;
      gnt_q     <= 2'b00;
      wptr_q    <= '0;
      rptr_q    <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      op_q  <= op_d;
      gnt_q <= gnt_next;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (wr_ok) begin
          wptr_q    <= wptr_q + 1'b1;
          wr_addr_q <= wptr_q[AW-1:0];
          wr_data_q <= gnt_next[1] ? din1 : din0;
        end
        if (rd_ok) begin
          rptr_q    <= rptr_q + 1'b1;
          rd_addr_q <= rptr_q[AW-1:0];
        end
      end
    end
  end

  // Strobes decode from op_q so reset removes them without waiting for an edge.
  assign wen      = (op_q == OP_WR) || (op_q == OP_WR_RD);
  assign ren      = (op_q == OP_RD) || (op_q == OP_WR_RD);
  assign rd_ack   = ren;
  assign gnt      = gnt_q;
  assign wr_addr  = wr_addr_q;
  assign rd_addr  = rd_addr_q;
  assign wr_data  = wr_data_q;
  assign op_state = op_q;

`ifdef FIFO_ARB_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      ovf_seen <= 1'b0;
      udf_seen <= 1'b0;
    end else begin
      if (|req_masked && full) ovf_seen <= 1'b1;
      if (rd_req && empty)     udf_seen <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed table-driven bench for fifo_arbiter plus hand sequences for reset corners.
module tb_fifo_arbiter;
  import fifo_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [14:0] din0 = '0, din1 = '0;
  logic        rd_req = 1'b0, flush = 1'b0;
  logic [1:0]  gnt;
  logic        rd_ack, wen, ren, full, empty;
  logic [2:0]  wr_addr, rd_addr;
  logic [14:0] wr_data;
  logic [3:0]  count;
  op_t         op_state;
`ifdef FIFO_ARB_ERR_EN
  logic        ovf_seen, udf_seen;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fifo_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .din0     (din0),
    .din1     (din1),
    .rd_req   (rd_req),
    .flush    (flush),
    .gnt      (gnt),
    .rd_ack   (rd_ack),
    .wen      (wen),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ren      (ren),
    .rd_addr  (rd_addr),
    .full     (full),
    .empty    (empty),
    .count    (count),
`ifdef FIFO_ARB_ERR_EN
    .ovf_seen (ovf_seen),
    .udf_seen (udf_seen),
`endif
    .op_state (op_state)
  );

  typedef struct {
    logic [1:0]  req;
    logic [14:0] d0;
    logic [14:0] d1;
    logic        rd;
    logic        fl;
    logic [1:0]  gnt;
    logic        wen;
    logic [2:0]  wa;
    logic [14:0] wd;
    logic        ren;
    logic [2:0]  ra;
    logic [3:0]  cnt;
    op_t         op;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // req d0 d1 rd fl | gnt wen wa wd ren ra cnt op ovf udf
    vecs[0]  = '{2'b01, 15'h1234, 15'h0000, 1'b0, 1'b0, 2'b01, 1'b1, 3'd0, 15'h1234, 1'b0, 3'd0, 4'd1, OP_WR,    1'b0, 1'b0};
    vecs[1]  = '{2'b00, 15'h0000, 15'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 15'h0000, 1'b0, 3'd0, 4'd1, OP_IDLE,  1'b0, 1'b0};
    vecs[2]  = '{2'b11, 15'h0aaa, 15'h0bbb, 1'b0, 1'b0, 2'b10, 1'b1, 3'd1, 15'h0bbb, 1'b0, 3'd0, 4'd2, OP_WR,    1'b0, 1'b0};
    vecs[3]  = '{2'b11, 15'h0aaa, 15'h0bbc, 1'b0, 1'b0, 2'b01, 1'b1, 3'd2, 15'h0aaa, 1'b0, 3'd0, 4'd3, OP_WR,    1'b0, 1'b0};
    vecs[4]  = '{2'b11, 15'h0aab, 15'h0bbc, 1'b0, 1'b0, 2'b10, 1'b1, 3'd3, 15'h0bbc, 1'b0, 3'd0, 4'd4, OP_WR,    1'b0, 1'b0};
    vecs[5]  = '{2'b11, 15'h0aab, 15'h0bbd, 1'b0, 1'b0, 2'b01, 1'b1, 3'd4, 15'h0aab, 1'b0, 3'd0, 4'd5, OP_WR,    1'b0, 1'b0};
    vecs[6]  = '{2'b00, 15'h0000, 15'h0000, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 15'h0000, 1'b1, 3'd0, 4'd4, OP_RD,    1'b0, 1'b0};
    vecs[7]  = '{2'b10, 15'h0000, 15'h0ccc, 1'b1, 1'b0, 2'b10, 1'b1, 3'd5, 15'h0ccc, 1'b1, 3'd1, 4'd4, OP_WR_RD, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 15'h0000, 15'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 15'h0000, 1'b0, 3'd0, 4'd4, OP_IDLE,  1'b0, 1'b0};
    vecs[9]  = '{2'b01, 15'h0101, 15'h0000, 1'b0, 1'b0, 2'b01, 1'b1, 3'd6, 15'h0101, 1'b0, 3'd0, 4'd5, OP_WR,    1'b0, 1'b0};
    vecs[10] = '{2'b00, 15'h0000, 15'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 15'h0000, 1'b0, 3'd0, 4'd5, OP_IDLE,  1'b0, 1'b0};
    vecs[11] = '{2'b01, 15'h0102, 15'h0000, 1'b0, 1'b0, 2'b01, 1'b1, 3'd7, 15'h0102, 1'b0, 3'd0, 4'd6, OP_WR,    1'b0, 1'b0};
    vecs[12] = '{2'b00, 15'h0000, 15'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 15'h0000, 1'b0, 3'd0, 4'd6, OP_IDLE,  1'b0, 1'b0};
    vecs[13] = '{2'b10, 15'h0000, 15'h0201, 1'b0, 1'b0, 2'b10, 1'b1, 3'd0, 15'h0201, 1'b0, 3'd0, 4'd7, OP_WR,    1'b0, 1'b0};
    vecs[14] = '{2'b01, 15'h0103, 15'h0000, 1'b0, 1'b0, 2'b01, 1'b1, 3'd1, 15'h0103, 1'b0, 3'd0, 4'd8, OP_WR,    1'b0, 1'b0};
    vecs[15] = '{2'b00, 15'h0000, 15'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 15'h0000, 1'b0, 3'd0, 4'd8, OP_IDLE,  1'b0, 1'b0};
    vecs[16] = '{2'b01, 15'h0104, 15'h0000, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 15'h0000, 1'b1, 3'd2, 4'd7, OP_RD,    1'b1, 1'b0};
    vecs[17] = '{2'b01, 15'h0104, 15'h0000, 1'b0, 1'b0, 2'b01, 1'b1, 3'd2, 15'h0104, 1'b0, 3'd0, 4'd8, OP_WR,    1'b1, 1'b0};
    vecs[18] = '{2'b00, 15'h0000, 15'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 15'h0000, 1'b0, 3'd0, 4'd8, OP_IDLE,  1'b1, 1'b0};
    vecs[19] = '{2'b01, 15'h0105, 15'h0000, 1'b0, 1'b1, 2'b00, 1'b0, 3'd0, 15'h0000, 1'b0, 3'd0, 4'd0, OP_FLUSH, 1'b0, 1'b0};
    vecs[20] = '{2'b00, 15'h0000, 15'h0000, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 15'h0000, 1'b0, 3'd0, 4'd0, OP_IDLE,  1'b0, 1'b1};
    vecs[21] = '{2'b10, 15'h0000, 15'h7fff, 1'b1, 1'b0, 2'b10, 1'b1, 3'd0, 15'h7fff, 1'b0, 3'd0, 4'd1, OP_WR,    1'b0, 1'b1};
    vecs[22] = '{2'b11, 15'h0001, 15'h0002, 1'b0, 1'b0, 2'b01, 1'b1, 3'd1, 15'h0001, 1'b0, 3'd0, 4'd2, OP_WR,    1'b0, 1'b1};
    vecs[23] = '{2'b00, 15'h0000, 15'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 15'h0000, 1'b0, 3'd0, 4'd2, OP_IDLE,  1'b0, 1'b1};
    vecs[24] = '{2'b11, 15'h0003, 15'h0004, 1'b0, 1'b0, 2'b10, 1'b1, 3'd2, 15'h0004, 1'b0, 3'd0, 4'd3, OP_WR,    1'b0, 1'b1};

    // Clock/reset and reset-state checks.
    step();
    step();
    check("rst op", 32'(op_state), 32'(OP_IDLE));
    check("rst gnt", 32'(gnt), 32'd0);
    check("rst wen", 32'(wen), 32'd0);
    check("rst ren", 32'(ren), 32'd0);
    check("rst rd_ack", 32'(rd_ack), 32'd0);
    check("rst wr_addr", 32'(wr_addr), 32'd0);
    check("rst rd_addr", 32'(rd_addr), 32'd0);
    check("rst wr_data", 32'(wr_data), 32'd0);
    check("rst count", 32'(count), 32'd0);
    check("rst empty", 32'(empty), 32'd1);
    check("rst full", 32'(full), 32'd0);
`ifdef FIFO_ARB_ERR_EN
    check("rst ovf", 32'(ovf_seen), 32'd0);
    check("rst udf", 32'(udf_seen), 32'd0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      req = vecs[i].req; din0 = vecs[i].d0; din1 = vecs[i].d1;
      rd_req = vecs[i].rd; flush = vecs[i].fl;
      step();
      check($sformatf("v%0d op", i), 32'(op_state), 32'(vecs[i].op));
      check($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("v%0d wen", i), 32'(wen), 32'(vecs[i].wen));
      check($sformatf("v%0d ren", i), 32'(ren), 32'(vecs[i].ren));
      check($sformatf("v%0d rd_ack", i), 32'(rd_ack), 32'(vecs[i].ren));
      check($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].cnt == 4'd8));
      check($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].cnt == 4'd0));
      if (vecs[i].wen) begin
        check($sformatf("v%0d wr_addr", i), 32'(wr_addr), 32'(vecs[i].wa));
        check($sformatf("v%0d wr_data", i), 32'(wr_data), 32'(vecs[i].wd));
      end
      if (vecs[i].ren)
        check($sformatf("v%0d rd_addr", i), 32'(rd_addr), 32'(vecs[i].ra));
`ifdef FIFO_ARB_ERR_EN
      check($sformatf("v%0d ovf", i), 32'(ovf_seen), 32'(vecs[i].ovf));
      check($sformatf("v%0d udf", i), 32'(udf_seen), 32'(vecs[i].udf));
`endif
    end

    // Reset mid-write: wen must drop before any further clock edge.
    req = 2'b01; din0 = 15'h5555; rd_req = 1'b0; flush = 1'b0;
    step();
    req = 2'b00;
    check("mid wen before reset", 32'(wen), 32'd1);
    check("mid wr_addr", 32'(wr_addr), 32'd3);
    check("mid count", 32'(count), 32'd4);
    #2 reset = 1'b1;
    #1;
    check("async wen", 32'(wen), 32'd0);
    check("async gnt", 32'(gnt), 32'd0);
    check("async count", 32'(count), 32'd0);
    check("async empty", 32'(empty), 32'd1);
    step();
    reset = 1'b0;
    // After reset last_q points at producer 1, so a tie goes to producer 0.
    req = 2'b11; din0 = 15'h0a0a; din1 = 15'h0b0b;
    step();
    req = 2'b00;
    check("post rst gnt", 32'(gnt), 32'b01);
    check("post rst wr_data", 32'(wr_data), 32'h0a0a);
    check("post rst wr_addr", 32'(wr_addr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
